// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite initiator: local cmd/rsp handshake to AXI-lite read/write.
// Optional bus watchdog when AXI_MST_TIMEOUT_EN is defined (SLVERR after TIMEOUT_CYCLES).
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_we,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [1:0]            b_response,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    // state     | meaning
    // S_IDLE    | cmd_ready high, waiting for a command
    // S_WR_REQ  | AW and W offered independently until both accepted
    // S_WR_RESP | b_ready high, waiting for the write response
    // S_RD_REQ  | AR offered until accepted
    // S_RD_DATA | r_ready high, waiting for read data
    // S_RSP     | rsp_valid held until the requester consumes it
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_RSP
    } state_t;

    state_t r_state;
    logic   r_aw_done;
    logic   r_w_done;
    logic   r_we;
    logic   w_aw_fire;
    logic   w_w_fire;
    logic   w_tmo;

    assign w_aw_fire = r_aw_done | (axi_awvalid & axi_awready);
    assign w_w_fire  = r_w_done  | (axi_wvalid  & axi_wready);

`ifdef AXI_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_tmo_cnt;

    // Only ever counts a couple of cycles past the limit, so the extra bit prevents wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tmo_cnt <= '0;
        else if (r_state == S_IDLE || r_state == S_RSP)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_tmo = (r_tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_we        <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            rsp_we      <= 1'b0;
            axi_awaddr  <= '0;
            axi_awvalid <= 1'b0;
            axi_wdata   <= '0;
            axi_wvalid  <= 1'b0;
            b_ready     <= 1'b0;
            axi_araddr  <= '0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        r_we      <= cmd_we;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (cmd_we) begin
                            axi_awaddr  <= cmd_addr;
                            axi_wdata   <= cmd_wdata;
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            r_state     <= S_WR_REQ;
                        end else begin
                            axi_araddr  <= cmd_addr;
                            axi_arvalid <= 1'b1;
                            r_state     <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (w_aw_fire && w_w_fire) begin
                        axi_awvalid <= 1'b0;
                        axi_wvalid  <= 1'b0;
                        r_aw_done   <= 1'b1;
                        r_w_done    <= 1'b1;
                        b_ready     <= 1'b1;
                        r_state     <= S_WR_RESP;
                    end else if (w_tmo) begin
                        axi_awvalid <= 1'b0;
                        axi_wvalid  <= 1'b0;
                        rsp_resp    <= 2'b10;
                        rsp_rdata   <= '0;
                        rsp_we      <= r_we;
                        rsp_valid   <= 1'b1;
                        r_state     <= S_RSP;
                    end else begin
                        if (axi_awvalid && axi_awready) begin
                            axi_awvalid <= 1'b0;
                            r_aw_done   <= 1'b1;
                        end
                        if (axi_wvalid && axi_wready) begin
                            axi_wvalid <= 1'b0;
                            r_w_done   <= 1'b1;
                        end
                    end
                end
                S_WR_RESP: begin
                    // A handshake on the timeout edge still reports the slave's result.
                    if (b_valid) begin
                        b_ready   <= 1'b0;
                        rsp_resp  <= b_response;
                        rsp_rdata <= '0;
                        rsp_we    <= r_we;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RSP;
                    end else if (w_tmo) begin
                        b_ready   <= 1'b0;
                        rsp_resp  <= 2'b10;
                        rsp_rdata <= '0;
                        rsp_we    <= r_we;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RSP;
                    end
                end
                S_RD_REQ: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        r_state     <= S_RD_DATA;
                    end else if (w_tmo) begin
                        axi_arvalid <= 1'b0;
                        rsp_resp    <= 2'b10;
                        rsp_rdata   <= '0;
                        rsp_we      <= r_we;
                        rsp_valid   <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RD_DATA: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        rsp_rdata  <= axi_rdata;
                        rsp_resp   <= 2'b00;
                        rsp_we     <= r_we;
                        rsp_valid  <= 1'b1;
                        r_state    <= S_RSP;
                    end else if (w_tmo) begin
                        axi_rready <= 1'b0;
                        rsp_resp   <= 2'b10;
                        rsp_rdata  <= '0;
                        rsp_we     <= r_we;
                        rsp_valid  <= 1'b1;
                        r_state    <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: directed vector table, reset/timeout sequences,
// and randomized transactions against a latency/result model of a delay-programmable slave.
module tb_axi_lite_master;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TMO    = 16;
    localparam int BUDGET = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_we;
    logic [AW-1:0] axi_awaddr, axi_araddr;
    logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [DW-1:0] axi_wdata, axi_rdata;
    logic          b_valid, b_ready;
    logic [1:0]    b_response;
    logic          axi_arvalid, axi_arready, axi_rvalid, axi_rready;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_we(rsp_we),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .b_valid(b_valid), .b_ready(b_ready), .b_response(b_response),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [1:0]    bresp;
        int            aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
        logic          r_early;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_resp;
        int            exp_lat;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations gathered by run_txn
    logic [DW-1:0] ob_rdata, ob_wdata;
    logic [AW-1:0] ob_awaddr, ob_araddr;
    logic [1:0]    ob_resp;
    logic          ob_we, ob_done, ob_post_cmd_ready, ob_post_rsp_valid, ob_busy_at_rsp;
    int            ob_lat, ob_ret, ob_viol, ob_naw, ob_nw, ob_nb, ob_nar, ob_nr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                                input logic [1:0] bresp, input int aw_dly, input int w_dly,
                                input int b_dly, input int ar_dly, input int r_dly,
                                input int rsp_dly, input logic r_early,
                                input logic [DW-1:0] exp_rdata, input logic [1:0] exp_resp,
                                input int exp_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.bresp = bresp;
        v.aw_dly = aw_dly; v.w_dly = w_dly; v.b_dly = b_dly;
        v.ar_dly = ar_dly; v.r_dly = r_dly; v.rsp_dly = rsp_dly; v.r_early = r_early;
        v.exp_rdata = exp_rdata; v.exp_resp = exp_resp; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Expected result: three pipeline cycles plus whatever the slave stalls each phase.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        int   m = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
        e.exp_lat   = v.we ? (3 + m + v.b_dly) : (3 + v.ar_dly + v.r_dly);
        e.exp_rdata = v.we ? '0 : v.rdata;
        e.exp_resp  = v.we ? v.bresp : 2'b00;
        return e;
    endfunction

    task automatic clear_inputs();
        cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
        axi_awready = 0; axi_wready = 0; b_valid = 0; b_response = 2'b00;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one command and plays the slave/requester; k counts cycles after acceptance.
    task automatic run_txn(input vec_t v);
        int   aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
        logic both_prev = 0, ar_prev = 0, r_raised = 0, hs_ar;
        logic prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, prev_arv = 0, prev_arr = 0;
        ob_lat = -1; ob_ret = -1; ob_viol = 0; ob_done = 0;
        ob_naw = 0; ob_nw = 0; ob_nb = 0; ob_nar = 0; ob_nr = 0;
        ob_rdata = '0; ob_resp = 2'b00; ob_we = 0; ob_busy_at_rsp = 0;
        ob_awaddr = '0; ob_wdata = '0; ob_araddr = '0;
        ob_post_cmd_ready = 0; ob_post_rsp_valid = 1;
        @(negedge clk);
        check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata;
        @(posedge clk);
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (ob_ret >= 0) begin
                ob_post_cmd_ready = cmd_ready;
                ob_post_rsp_valid = rsp_valid;
                ob_done = 1;
                break;
            end
            cmd_we = ~v.we; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
            if (cmd_ready) ob_viol++;
            if (prev_awv && !prev_awr && !axi_awvalid) ob_viol++;
            if (prev_wv && !prev_wr && !axi_wvalid) ob_viol++;
            if (prev_arv && !prev_arr && !axi_arvalid) ob_viol++;
            if (axi_awvalid && axi_awaddr !== v.addr) ob_viol++;
            if (axi_wvalid && axi_wdata !== v.wdata) ob_viol++;
            if (axi_arvalid && axi_araddr !== v.addr) ob_viol++;
            if (b_ready && (ob_naw == 0 || ob_nw == 0)) ob_viol++;
            if (axi_rready && ob_nar == 0) ob_viol++;
            if (rsp_valid) begin
                if (ob_lat < 0) begin
                    ob_lat = k; ob_rdata = rsp_rdata; ob_resp = rsp_resp; ob_we = rsp_we;
                    ob_busy_at_rsp = axi_awvalid | axi_wvalid | b_ready | axi_arvalid | axi_rready;
                end else if (rsp_rdata !== ob_rdata || rsp_resp !== ob_resp || rsp_we !== ob_we)
                    ob_viol++;
            end else if (ob_lat >= 0) ob_viol++;
            b_valid    = both_prev && ob_nb == 0 && b_cnt >= v.b_dly;
            b_response = b_valid ? v.bresp : 2'($urandom);
            if (both_prev) b_cnt++;
            if (b_valid && b_ready) ob_nb++;
            axi_awready = axi_awvalid && aw_cnt >= v.aw_dly;
            if (axi_awvalid) aw_cnt++;
            if (axi_awvalid && axi_awready) begin ob_naw++; ob_awaddr = axi_awaddr; end
            axi_wready = axi_wvalid && w_cnt >= v.w_dly;
            if (axi_wvalid) w_cnt++;
            if (axi_wvalid && axi_wready) begin ob_nw++; ob_wdata = axi_wdata; end
            both_prev = ob_naw > 0 && ob_nw > 0;
            axi_arready = axi_arvalid && ar_cnt >= v.ar_dly;
            if (axi_arvalid) ar_cnt++;
            hs_ar = axi_arvalid && axi_arready;
            if (hs_ar) begin ob_nar++; ob_araddr = axi_araddr; end
            axi_rvalid = ob_nr == 0 && (r_raised || (ar_prev && r_cnt >= v.r_dly) || (v.r_early && hs_ar));
            axi_rdata  = axi_rvalid ? v.rdata : $urandom;
            if (ar_prev) r_cnt++;
            if (axi_rvalid && axi_rready) ob_nr++;
            r_raised = axi_rvalid && ob_nr == 0;
            ar_prev  = ob_nar > 0;
            rsp_ready = rsp_valid && rsp_cnt >= v.rsp_dly;
            if (rsp_valid) rsp_cnt++;
            if (rsp_valid && rsp_ready) ob_ret = k;
            prev_awv = axi_awvalid; prev_awr = axi_awready;
            prev_wv  = axi_wvalid;  prev_wr  = axi_wready;
            prev_arv = axi_arvalid; prev_arr = axi_arready;
        end
        clear_inputs();
        check("txn_completed", {63'd0, ob_done}, 64'd1);
        if (!ob_done) do_reset();
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        check({tag, ".latency"}, 64'(ob_lat), 64'(v.exp_lat));
        check({tag, ".rsp_rdata"}, 64'(ob_rdata), 64'(v.exp_rdata));
        check({tag, ".rsp_resp"}, 64'(ob_resp), 64'(v.exp_resp));
        check({tag, ".rsp_we"}, 64'(ob_we), 64'(v.we));
        check({tag, ".handoff"}, 64'(ob_ret), 64'(v.exp_lat + v.rsp_dly));
        check({tag, ".post_ready"}, {62'd0, ob_post_cmd_ready, ob_post_rsp_valid}, 64'd2);
        check({tag, ".protocol"}, 64'(ob_viol), 64'd0);
        check({tag, ".bus_idle_in_rsp"}, 64'(ob_busy_at_rsp), 64'd0);
        if (v.we) begin
            check({tag, ".awaddr"}, 64'(ob_awaddr), 64'(v.addr));
            check({tag, ".wdata"}, 64'(ob_wdata), 64'(v.wdata));
            check({tag, ".hs_counts"}, {ob_naw[7:0], ob_nw[7:0], ob_nb[7:0], ob_nar[7:0], ob_nr[7:0]},
                  {8'd1, 8'd1, 8'd1, 8'd0, 8'd0});
        end else begin
            check({tag, ".araddr"}, 64'(ob_araddr), 64'(v.addr));
            check({tag, ".hs_counts"}, {ob_naw[7:0], ob_nw[7:0], ob_nb[7:0], ob_nar[7:0], ob_nr[7:0]},
                  {8'd0, 8'd0, 8'd0, 8'd1, 8'd1});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        vec_t v;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("reset.ctrl", {56'd0, axi_awvalid, axi_wvalid, b_ready, axi_arvalid, axi_rready,
                             rsp_valid, rsp_we, |rsp_resp}, 64'd0);
        check("reset.data", {rsp_rdata, axi_awaddr}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //            we addr        wdata         rdata         br     aw w  b  ar r  rsp e  exp_rd        er     lat
        tbl[0] = mk(1, 32'h4,  32'h0000_00A5, 32'h0,         2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 3);
        tbl[1] = mk(1, 32'h10, 32'hDEAD_BEEF, 32'h0,         2'b00, 0, 3, 0, 0, 0, 0, 0, 32'h0,         2'b00, 6);
        tbl[2] = mk(1, 32'h20, 32'h0000_1234, 32'h0,         2'b10, 3, 0, 2, 0, 0, 0, 0, 32'h0,         2'b10, 8);
        tbl[3] = mk(0, 32'h0,  32'h0,         32'h0000_0009, 2'b00, 0, 0, 0, 0, 2, 0, 0, 32'h0000_0009, 2'b00, 5);
        tbl[4] = mk(0, 32'h8,  32'h0,         32'hCAFE_F00D, 2'b00, 0, 0, 0, 2, 0, 5, 0, 32'hCAFE_F00D, 2'b00, 5);
        tbl[5] = mk(0, 32'h30, 32'h0,         32'h5555_AAAA, 2'b00, 0, 0, 0, 1, 0, 0, 1, 32'h5555_AAAA, 2'b00, 4);
        tbl[6] = mk(1, 32'h44, 32'h0F0F_0F0F, 32'h0,         2'b11, 0, 0, 0, 0, 0, 5, 0, 32'h0,         2'b11, 3);
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i]);
            check_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset while the write is stalled in its request phase.
        @(negedge clk);
        cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h40; cmd_wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        check("rst_mid.in_wr_req", {62'd0, axi_awvalid, axi_wvalid}, 64'd3);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.async_clear", {60'd0, axi_awvalid, axi_wvalid, cmd_ready, rsp_valid}, 64'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid.after_release", {61'd0, cmd_ready, rsp_valid, b_ready}, 64'd4);
        run_txn(tbl[0]);
        check_txn("rst_mid.recover", tbl[0]);

        for (int i = 0; i < 40; i++) begin
            v = mk($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                   2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 5),
                   $urandom_range(0, 3), 0, 32'h0, 2'b00, 0);
            v = model(v);
            run_txn(v);
            check_txn($sformatf("rnd%0d", i), v);
        end

`ifdef AXI_MST_TIMEOUT_EN
        v = mk(0, 32'h50, 32'h0, 32'h1111_2222, 2'b00, 0, 0, 0, 10000, 0, 0, 0, 32'h0, 2'b10, TMO + 1);
        run_txn(v);
        check("tmo.latency", 64'(ob_lat), 64'(v.exp_lat));
        check("tmo.rsp_resp", 64'(ob_resp), 64'(v.exp_resp));
        check("tmo.rsp_rdata", 64'(ob_rdata), 64'(v.exp_rdata));
        check("tmo.bus_idle", 64'(ob_busy_at_rsp), 64'd0);
        check("tmo.no_ar_hs", 64'(ob_nar), 64'd0);
        check("tmo.post_ready", {62'd0, ob_post_cmd_ready, ob_post_rsp_valid}, 64'd2);
        // Address accepted on the very edge the watchdog expires: the slave's data wins.
        v = model(mk(0, 32'h54, 32'h0, 32'h3333_4444, 2'b00, 0, 0, 0, TMO - 1, 0, 0, 0, 32'h0, 2'b00, 0));
        run_txn(v);
        check_txn("tmo_edge", v);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
